// File: rtl/multi_blink_pkg.sv
// multi_blink_pkg: shared mode encoding, register field positions and status address
package multi_blink_pkg;
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;
    localparam int MODE_LSB = 16;
    localparam int MODE_MSB = 17;
    localparam logic [4:0] STATUS_ADDR = 5'd31;
endpackage

// File: rtl/multi_blink_core_channel.sv
// blink_channel: one LED channel holding its half-period, mode, ms-tick counter and LED flop
module blink_channel
    import multi_blink_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_we,
    input  logic [PERIOD_W-1:0] i_half,
    input  mode_e               i_mode,
    input  logic                i_tick,
    output logic [PERIOD_W-1:0] o_half,
    output mode_e               o_mode,
    output logic                o_led
);
    logic [PERIOD_W-1:0] r_half, r_cnt, w_half_nx, w_cnt_nx;
    mode_e               r_mode, w_mode_nx;
    logic                r_led, w_led_nx, w_last;
    assign w_last = r_cnt == r_half - PERIOD_W'(1);
    always_comb begin
        w_half_nx = r_half;
        w_mode_nx = r_mode;
        w_cnt_nx  = r_cnt;
        w_led_nx  = r_led;
        if (i_we) begin
            // a write restarts the phase and beats any tick in the same cycle
            w_half_nx = i_half;
            w_mode_nx = i_mode;
            w_cnt_nx  = '0;
            w_led_nx  = i_mode == MODE_ON || (i_mode == MODE_ONESHOT && i_half != '0);
        end else begin
            case (r_mode)
                MODE_OFF: w_led_nx = 1'b0;
                MODE_ON:  w_led_nx = 1'b1;
                default: begin
                    if (r_half == '0) begin
                        w_led_nx = 1'b0;
                        w_cnt_nx = '0;
                    end else if (i_tick) begin
                        w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            w_led_nx = r_mode == MODE_BLINK ? ~r_led : 1'b0;
                            if (r_mode == MODE_ONESHOT) w_mode_nx = MODE_OFF;
                        end
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_half <= '0;
            r_mode <= MODE_OFF;
            r_cnt  <= '0;
            r_led  <= 1'b0;
        end else begin
            r_half <= w_half_nx;
            r_mode <= w_mode_nx;
            r_cnt  <= w_cnt_nx;
            r_led  <= w_led_nx;
        end
    end
    assign o_half = r_half;
    assign o_mode = r_mode;
    assign o_led  = r_led;
endmodule

// File: rtl/multi_blink_core.sv
// multi_blink_core: register-mapped multi-channel LED blinker sharing one ms prescaler
module multi_blink_core
    import multi_blink_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PERIOD_W   = 16,
    parameter int CLK_PER_MS = 100_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic [N_CH-1:0] led_out
);
    localparam int PS_W = $clog2(CLK_PER_MS);
    logic [PS_W-1:0]     r_presc;
    logic                w_tick, w_unused;
    logic [PERIOD_W-1:0] w_half [N_CH];
    mode_e               w_mode [N_CH];
    // reads are side-effect free, and wr_data bits outside the fields are dropped
    assign w_unused = ^{read, wr_data};
    assign w_tick = r_presc == PS_W'(CLK_PER_MS - 1);
    always_ff @(posedge clk) begin
        if (reset) r_presc <= '0;
        else       r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        blink_channel #(.PERIOD_W(PERIOD_W)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .i_we   (cs && write && addr == 5'(i)),
            .i_half (wr_data[PERIOD_W-1:0]),
            .i_mode (mode_e'(wr_data[MODE_MSB:MODE_LSB])),
            .i_tick (w_tick),
            .o_half (w_half[i]),
            .o_mode (w_mode[i]),
            .o_led  (led_out[i])
        );
    end
    always_comb begin
        rd_data = '0;
        if (addr == STATUS_ADDR) rd_data[N_CH-1:0] = led_out;
        for (int k = 0; k < N_CH; k++) begin
            if (addr == 5'(k)) begin
                rd_data[PERIOD_W-1:0]      = w_half[k];
                rd_data[MODE_MSB:MODE_LSB] = w_mode[k];
            end
        end
    end
endmodule

// File: tb/tb_multi_blink_core.sv
// tb_multi_blink_core: directed stimulus checked against a tick-count model of each channel
module tb_multi_blink_core;
    localparam int N_CH = 4;
    localparam int PW   = 16;
    localparam int CPM  = 10;

    logic            clk = 1'b0, reset = 1'b1, cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]      addr = '0;
    logic [31:0]     wr_data = '0, rd_data;
    logic [N_CH-1:0] led_out;

    multi_blink_core #(.N_CH(N_CH), .PERIOD_W(PW), .CLK_PER_MS(CPM)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Model: each channel remembers its fields and how many ms ticks passed since its last write
    int          m_c;
    bit          m_tick, started;
    logic [15:0] m_half [N_CH];
    logic [1:0]  m_mode [N_CH];
    int          m_t    [N_CH];

    function automatic logic m_led(input int ch);
        int h;
        h = int'(m_half[ch]);
        case (m_mode[ch])
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return h != 0 && ((m_t[ch] / (h == 0 ? 1 : h)) % 2) == 1;
            default: return h != 0 && m_t[ch] < h;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        logic [31:0] v;
        v = '0;
        if (a == 5'd31) for (int ch = 0; ch < N_CH; ch++) v[ch] = m_led(ch);
        else if (int'(a) < N_CH) v = {14'b0, m_mode[a], m_half[a]};
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_c = 0;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_half[ch] = '0; m_mode[ch] = '0; m_t[ch] = 0;
            end
        end else begin
            m_tick = (m_c % CPM) == CPM - 1;
            m_c++;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (cs && write && int'(addr) == ch) begin
                    m_half[ch] = wr_data[15:0];
                    m_mode[ch] = wr_data[17:16];
                    m_t[ch]    = 0;
                end else if (m_tick) begin
                    m_t[ch]++;
                    if (m_mode[ch] == 2'b11 && m_half[ch] != 0 && m_t[ch] >= int'(m_half[ch])) m_mode[ch] = 2'b00;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("led_vs_model", 32'(led_out), 32'(m_rd(5'd31)));
            chk("rd_vs_model", rd_data, m_rd(addr));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        step(1);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a; read = 1'b1;
        #1;
        chk(name, rd_data, exp);
        read = 1'b0;
        step(1);
    endtask

    task automatic wait_led(input int ch, input logic v, input int budget, output int k);
        k = -1;
        for (int j = 1; j <= budget && k < 0; j++) begin
            step(1);
            if (led_out[ch] === v) k = j;
        end
    endtask

    int k;

    initial begin
        step(2);
        reset = 1'b0;
        chk("reset_led", 32'(led_out), 32'h0);
        for (int a = 0; a < N_CH; a++) rd("reset_reg", 5'(a), 32'h0);
        rd("reset_status", 5'd31, 32'h0);

        wr(5'd1, 32'h0002_0003);
        rd("blink_reg", 5'd1, 32'h0002_0003);
        wait_led(1, 1'b1, 40, k);
        chk("blink_first_rise_window", 32'(k >= 20 && k <= 30), 32'h1);
        wait_led(1, 1'b0, 40, k);
        chk("blink_fall_interval", 32'(k), 32'd30);
        wait_led(1, 1'b1, 40, k);
        chk("blink_rise_interval", 32'(k), 32'd30);

        wr(5'd2, 32'h0003_0005);
        chk("oneshot_on", 32'(led_out[2]), 32'h1);
        wait_led(2, 1'b0, 60, k);
        chk("oneshot_off_window", 32'(k >= 41 && k <= 50), 32'h1);
        rd("oneshot_mode_off", 5'd2, 32'h0000_0005);

        wr(5'd1, 32'h0);
        wr(5'd0, 32'h0001_0000);
        chk("on_led", 32'(led_out[0]), 32'h1);
        wr(5'd3, 32'h0002_0000);
        step(25);
        chk("h0_led", 32'(led_out[3]), 32'h0);
        rd("status_on_only", 5'd31, 32'h1);
        rd("h0_reg", 5'd3, 32'h0002_0000);
        wr(5'd0, 32'hFFF1_0007);
        rd("trunc_reg", 5'd0, 32'h0001_0007);

        wr(5'd1, 32'h0002_0003);
        wait_led(1, 1'b1, 40, k);
        chk("rise_before_collision", 32'(k > 0), 32'h1);
        for (int j = 0; j < 2 * CPM && (m_c % CPM) != CPM - 1; j++) step(1);
        wr(5'd1, 32'h0002_0003);
        chk("collision_led_cleared", 32'(led_out[1]), 32'h0);
        wait_led(1, 1'b1, 40, k);
        chk("collision_restart", 32'(k), 32'd30);
        wr(5'd10, 32'hFFFF_FFFF);
        rd("unmapped_read", 5'd10, 32'h0);

        wait_led(1, 1'b1, 70, k);
        chk("blink_on_before_reset", 32'(k > 0), 32'h1);
        reset = 1'b1; cs = 1'b1; write = 1'b1; addr = 5'd0; wr_data = 32'h0001_0000;
        step(1);
        reset = 1'b0; cs = 1'b0; write = 1'b0; wr_data = '0;
        chk("reset_mid_led", 32'(led_out), 32'h0);
        for (int a = 0; a < N_CH; a++) rd("reset_mid_reg", 5'(a), 32'h0);
        rd("reset_mid_status", 5'd31, 32'h0);
        step(40);
        chk("stay_off_after_reset", 32'(led_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
